// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART transmitter.
// The optional line-break state is compiled in when UART_TX_BREAK_EN is defined.
package uart_pkg;

  // Transmitter states; BREAK exists only when break support is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } state_e;

  // Data-bit count encoding (5..8 bits).
  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } bits_e;

  // Parity encoding; 2'b11 is an alias for "no parity".
  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  // Stop-bit encoding; 2'b11 is an alias for two stop bits.
  typedef enum logic [1:0] {
    STOP_1     = 2'b00,
    STOP_1P5   = 2'b01,
    STOP_2     = 2'b10,
    STOP_2_ALT = 2'b11
  } stop_e;

  // Number of data bits carried by a frame.
  function automatic int data_bits(bits_e b);
    return 5 + int'(b);
  endfunction

  // True when a parity bit follows the data bits.
  function automatic logic parity_enabled(parity_e p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

  // Length of the stop period in baud ticks.
  function automatic int stop_ticks(stop_e s, int os);
    int t;
    case (s)
      STOP_1:   t = os;
      STOP_1P5: t = (3 * os) / 2;
      default:  t = 2 * os;
    endcase
    return t;
  endfunction

  // Even parity (XOR) of the low n bits of a word; higher bits are ignored.
  function automatic logic masked_parity(logic [7:0] d, int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: run-time configurable UART transmitter (5-8 data bits,
// none/even/odd parity, 1/1.5/2 stop bits) paced by an external baud tick
// (OVERSAMPLE ticks per bit). Define UART_TX_BREAK_EN to add the break_i
// input and the BREAK state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_WORD_BITS = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     baud_i,
  input  logic [1:0]               cfg_bits_i,
  input  logic [1:0]               cfg_parity_i,
  input  logic [1:0]               cfg_stop_i,
  input  logic                     tx_valid_i,
  input  logic [MAX_WORD_BITS-1:0] tx_data_i,
`ifdef UART_TX_BREAK_EN
  input  logic                     break_i,
`endif
  output logic                     tx_ready_o,
  output logic                     tx_busy_o,
  output logic                     tx_done_o,
  output logic                     tx_o
);

  localparam int                TICK_W   = $clog2(2 * OVERSAMPLE);
  localparam logic [TICK_W-1:0] BIT_LAST = TICK_W'(OVERSAMPLE - 1);

  state_e                   r_state;
  logic [TICK_W-1:0]        r_tick;
  logic [2:0]               r_bit_idx;
  logic [MAX_WORD_BITS-1:0] r_shift;
  bits_e                    r_bits;
  parity_e                  r_parity;
  stop_e                    r_stop;
  logic                     r_par_bit;
  logic                     r_frame;   // 1: data frame (pulse done), 0: break recovery
  logic                     r_tx;
  logic                     r_ready;
  logic                     r_busy;
  logic                     r_done;

  logic [TICK_W-1:0]        w_stop_last;
  logic                     w_bit_end;
  logic                     w_stop_end;
  logic                     w_last_bit;
  logic                     w_par_bit;

  // Tick index of the final stop tick for the latched stop setting.
  assign w_stop_last = TICK_W'(stop_ticks(r_stop, OVERSAMPLE) - 1);
  assign w_bit_end   = baud_i && (r_tick == BIT_LAST);
  assign w_stop_end  = baud_i && (r_tick == w_stop_last);
  assign w_last_bit  = (r_bit_idx == 3'(data_bits(r_bits) - 1));

  // Parity bit of the incoming word, computed once at acceptance.
  assign w_par_bit = masked_parity(tx_data_i[7:0], data_bits(bits_e'(cfg_bits_i)))
                   ^ (parity_e'(cfg_parity_i) == PAR_ODD);

  // Frame sequencer: state, tick/bit counters, shift register and registered outputs.
  // NOTE: every register here uses <= so all updates see the pre-edge values;
  // blocking assignments would make r_tx depend on statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_bits    <= BITS_5;
      r_parity  <= PAR_NONE;
      r_stop    <= STOP_1;
      r_par_bit <= 1'b0;
      r_frame   <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_i) begin
            r_state <= ST_BREAK;
            r_stop  <= stop_e'(cfg_stop_i);
            r_frame <= 1'b0;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else
`endif
          if (tx_valid_i) begin
            r_state   <= ST_START;
            r_shift   <= tx_data_i;
            r_bits    <= bits_e'(cfg_bits_i);
            r_parity  <= parity_e'(cfg_parity_i);
            r_stop    <= stop_e'(cfg_stop_i);
            r_par_bit <= w_par_bit;
            r_bit_idx <= '0;
            r_frame   <= 1'b1;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_tick  <= '0;
            r_tx    <= r_shift[0];
          end else if (baud_i) begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_tick <= '0;
            if (!w_last_bit) begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end else if (parity_enabled(r_parity)) begin
              r_state <= ST_PARITY;
              r_tx    <= r_par_bit;
            end else begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end
          end else if (baud_i) begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_PARITY: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_tick  <= '0;
            r_tx    <= 1'b1;
          end else if (baud_i) begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_stop_end) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= r_frame;
          end else if (baud_i) begin
            r_tick <= r_tick + 1'b1;
          end
        end

`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          if (!break_i) begin
            r_state <= ST_STOP;
            r_tick  <= '0;
            r_tx    <= 1'b1;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_tick  <= '0;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_BREAK_EN
  // A rising break_i in IDLE wins over tx_valid_i, so ready drops in that same
  // cycle to keep upstream from seeing a handshake that never happens.
  assign tx_ready_o = r_ready && !break_i;
`else
  assign tx_ready_o = r_ready;
`endif
  assign tx_busy_o = r_busy;
  assign tx_done_o = r_done;
  assign tx_o      = r_tx;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg. The driver pushes the
// expected frame when it issues a word; a monitor decodes the serial line
// tick by tick and compares against a frame model built from the word and
// its configuration.
module tb_uart_tx_cfg;

  localparam int OS         = 16;
  localparam int W          = 8;
  localparam int ACC_BOUND  = 4000;
  localparam int IDLE_BOUND = 4000;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         baud_i;
  logic [1:0]   cfg_bits_i;
  logic [1:0]   cfg_parity_i;
  logic [1:0]   cfg_stop_i;
  logic         tx_valid_i;
  logic [W-1:0] tx_data_i;
  logic         tx_ready_o;
  logic         tx_busy_o;
  logic         tx_done_o;
  logic         tx_o;
`ifdef UART_TX_BREAK_EN
  logic         break_i;
`endif

  uart_tx_cfg #(.MAX_WORD_BITS(W), .OVERSAMPLE(OS)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .baud_i       (baud_i),
    .cfg_bits_i   (cfg_bits_i),
    .cfg_parity_i (cfg_parity_i),
    .cfg_stop_i   (cfg_stop_i),
    .tx_valid_i   (tx_valid_i),
    .tx_data_i    (tx_data_i),
`ifdef UART_TX_BREAK_EN
    .break_i      (break_i),
`endif
    .tx_ready_o   (tx_ready_o),
    .tx_busy_o    (tx_busy_o),
    .tx_done_o    (tx_done_o),
    .tx_o         (tx_o)
  );

  always #5 clk_i = ~clk_i;

  // Frame description derived from the word and its configuration.
  typedef struct {
    logic [7:0] data;
    int         nbits;
    int         par;     // 0 none, 1 even, 2 odd
    int         stop_t;  // stop length in ticks
  } frame_t;

  frame_t exp_q[$];
  int     n_checks    = 0;
  int     n_errors    = 0;
  int     cyc         = 0;
  int     done_cycle  = -100;
  int     last_gap    = 0;
  int     frames_done = 0;
  int     spurious    = 0;
  int     mon_seg     = 0;
  bit     mon_in_frame = 1'b0;
  bit     mon_en       = 1'b1;
  int     baud_mode    = 0;   // 0: tick every cycle, 1: random ticks

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] b,
                                        input logic [1:0] p, input logic [1:0] s);
    frame_t f;
    f.data   = d;
    f.nbits  = 5 + int'(b);
    f.par    = (p == 2'd1) ? 1 : (p == 2'd2) ? 2 : 0;
    f.stop_t = (s == 2'd0) ? OS : (s == 2'd1) ? (OS * 3) / 2 : 2 * OS;
    return f;
  endfunction

  function automatic int nseg(input frame_t f);
    return 1 + f.nbits + ((f.par != 0) ? 1 : 0) + 1;
  endfunction

  function automatic int seg_dur(input frame_t f, input int i);
    return (i == nseg(f) - 1) ? f.stop_t : OS;
  endfunction

  function automatic logic seg_level(input frame_t f, input int i);
    int ones;
    if (i == 0) return 1'b0;
    if (i <= f.nbits) return f.data[i-1];
    if (f.par != 0 && i == f.nbits + 1) begin
      ones = 0;
      for (int k = 0; k < f.nbits; k++) ones += int'(f.data[k]);
      return (f.par == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  // Baud tick source, updated on the falling edge.
  initial begin
    baud_i = 1'b0;
    forever begin
      @(negedge clk_i);
      baud_i = (baud_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: samples just after each rising edge and walks the expected frame.
  initial begin : monitor
    frame_t f;
    int     seg;
    int     ticks;
    int     line_err;
    int     ctl_err;
    int     fid;
    bit     in_fr;
    fid   = 0;
    in_fr = 1'b0;
    seg   = 0;
    ticks = 0;
    line_err = 0;
    ctl_err  = 0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (reset_i || !mon_en) begin
        in_fr = 1'b0;
        if (reset_i && tx_done_o !== 1'b0) spurious++;
      end else if (!in_fr) begin
        if (tx_done_o !== 1'b0) spurious++;
        if (tx_o === 1'b0) begin
          if (exp_q.size() == 0) begin
            spurious++;
          end else begin
            f        = exp_q.pop_front();
            in_fr    = 1'b1;
            seg      = 0;
            ticks    = 0;
            line_err = 0;
            ctl_err  = 0;
            last_gap = cyc - done_cycle;
            if (tx_ready_o !== 1'b0 || tx_busy_o !== 1'b1) ctl_err++;
          end
        end
      end else begin
        if (baud_i) ticks++;
        if (ticks == seg_dur(f, seg)) begin
          seg++;
          ticks = 0;
        end
        if (seg == nseg(f)) begin
          if (tx_o !== 1'b1) line_err++;
          if (tx_done_o !== 1'b1 || tx_ready_o !== 1'b1 || tx_busy_o !== 1'b0) ctl_err++;
          check($sformatf("frame %0d data %02h line errors", fid, f.data), line_err, 0);
          check($sformatf("frame %0d data %02h handshake errors", fid, f.data), ctl_err, 0);
          done_cycle = cyc;
          frames_done++;
          fid++;
          in_fr = 1'b0;
        end else begin
          if (tx_o !== seg_level(f, seg)) line_err++;
          if (tx_done_o !== 1'b0 || tx_ready_o !== 1'b0 || tx_busy_o !== 1'b1) ctl_err++;
        end
      end
      mon_seg      = seg;
      mon_in_frame = in_fr;
    end
  end

  // Offer a word; push its expected frame just before the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] b, input logic [1:0] p,
                      input logic [1:0] s, input bit hold);
    int n;
    n = 0;
    tx_data_i    = d;
    cfg_bits_i   = b;
    cfg_parity_i = p;
    cfg_stop_i   = s;
    tx_valid_i   = 1'b1;
    while (tx_ready_o !== 1'b1 && n < ACC_BOUND) begin
      @(negedge clk_i);
      n++;
    end
    check("word accepted in time", int'(n < ACC_BOUND), 1);
    if (n < ACC_BOUND) begin
      exp_q.push_back(make_frame(d, b, p, s));
      @(negedge clk_i);
    end
    if (!hold) tx_valid_i = 1'b0;
    // Disturb data and configuration mid-frame; they must already be latched.
    tx_data_i    = W'($urandom);
    cfg_bits_i   = 2'($urandom);
    cfg_parity_i = 2'($urandom);
    cfg_stop_i   = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_in_frame) && n < IDLE_BOUND) begin
      @(negedge clk_i);
      n++;
    end
    check("frames drained in time", int'(n < IDLE_BOUND), 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int fd0;
    int n;
    bit h;
    reset_i      = 1'b1;
    tx_valid_i   = 1'b0;
    tx_data_i    = '0;
    cfg_bits_i   = 2'b11;
    cfg_parity_i = 2'b00;
    cfg_stop_i   = 2'b00;
`ifdef UART_TX_BREAK_EN
    break_i      = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    check("reset tx_o", int'(tx_o), 1);
    check("reset tx_ready_o", int'(tx_ready_o), 1);
    check("reset tx_busy_o", int'(tx_busy_o), 0);
    check("reset tx_done_o", int'(tx_done_o), 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // 8N1 0xA5
    fd0 = frames_done;
    send(8'hA5, 2'b11, 2'b00, 2'b00, 1'b0);
    wait_idle();
    check("8N1 A5 done pulses", frames_done - fd0, 1);

    // 7E2 0xC1 (bit 7 ignored)
    send(8'hC1, 2'b10, 2'b01, 2'b10, 1'b0);
    wait_idle();

    // 5O1.5 0xFF
    send(8'hFF, 2'b00, 2'b10, 2'b01, 1'b0);
    wait_idle();

    // Back-to-back with valid held high
    fd0 = frames_done;
    send(8'h55, 2'b11, 2'b00, 2'b00, 1'b1);
    send(8'h0F, 2'b11, 2'b00, 2'b00, 1'b1);
    tx_valid_i = 1'b0;
    wait_idle();
    check("back-to-back done pulses", frames_done - fd0, 2);
    check("back-to-back gap cycles", last_gap, 1);

    // Reset during data bit 3, then a clean frame
    fd0 = frames_done;
    send(8'hB4, 2'b11, 2'b00, 2'b00, 1'b0);
    n = 0;
    while (!(mon_in_frame && mon_seg == 4) && n < IDLE_BOUND) begin
      @(negedge clk_i);
      n++;
    end
    check("reached data bit 3", int'(n < IDLE_BOUND), 1);
    reset_i = 1'b1;
    exp_q.delete();
    #1;
    check("mid-frame reset tx_o", int'(tx_o), 1);
    check("mid-frame reset tx_ready_o", int'(tx_ready_o), 1);
    check("mid-frame reset tx_busy_o", int'(tx_busy_o), 0);
    check("mid-frame reset tx_done_o", int'(tx_done_o), 0);
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    check("aborted frame gives no done", frames_done - fd0, 0);
    send(8'h3C, 2'b11, 2'b00, 2'b00, 1'b0);
    wait_idle();
    check("frame after reset done", frames_done - fd0, 1);

`ifdef UART_TX_BREAK_EN
    // Break for 40 cycles with a word pending; stop length latched at entry
    begin
      int bad;
      mon_en       = 1'b0;
      tx_data_i    = 8'h96;
      cfg_bits_i   = 2'b11;
      cfg_parity_i = 2'b00;
      cfg_stop_i   = 2'b10;
      tx_valid_i   = 1'b1;
      break_i      = 1'b1;
      #1;
      check("break blocks ready", int'(tx_ready_o), 0);
      bad = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk_i);
        if (i == 1) cfg_stop_i = 2'b00;
        if (tx_o !== 1'b0 || tx_ready_o !== 1'b0 || tx_done_o !== 1'b0) bad++;
      end
      check("break line low", bad, 0);
      break_i = 1'b0;
      bad = 0;
      n = 0;
      while (tx_ready_o !== 1'b1 && n < 200) begin
        @(negedge clk_i);
        n++;
        if (tx_o !== 1'b1 || tx_done_o !== 1'b0) bad++;
      end
      check("break stop cycles", n, 2 * OS + 1);
      check("break stop line high", bad, 0);
      exp_q.push_back(make_frame(8'h96, 2'b11, 2'b00, 2'b00));
      mon_en = 1'b1;
      @(negedge clk_i);
      tx_valid_i = 1'b0;
      wait_idle();
    end
`endif

    // Randomized frames with irregular baud ticks
    baud_mode = 1;
    for (int i = 0; i < 30; i++) begin
      h = ($urandom_range(0, 3) == 0);
      send(8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), h);
      if (!h) repeat ($urandom_range(0, 4)) @(negedge clk_i);
    end
    tx_valid_i = 1'b0;
    wait_idle();

    check("spurious done or start events", spurious, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, run-time configurable UART transmitter. It serialises one word per frame using a valid/ready handshake and supports 5–8 data bits, none/even/odd parity, and 1/1.5/2 stop bits. It sits between the TX FIFO (upstream, valid/ready) and the pad. It is paced by the shared external baud generator tick (OVERSAMPLE ticks per bit).

Parameters:
- MAX_WORD_BITS, 8: width of tx_data_i; must be ≥8. Only the configured number of LSBs is sent.
- OVERSAMPLE, 16: baud ticks per bit. Must be even and ≥4.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- baud_i  in  1  one-cycle baud tick
- cfg_bits_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- cfg_parity_i  in  2  00=none, 01=even, 10=odd, 11=none
- cfg_stop_i  in  2  00=1, 01=1.5, 10=2, 11=2 stop bits
- tx_valid_i  in  1  upstream word valid
- tx_data_i  in  MAX_WORD_BITS  word, LSB first
- tx_ready_o  out  1  block can accept a word
- tx_busy_o  out  1  frame in progress
- tx_done_o  out  1  one-cycle pulse at end of frame
- tx_o  out  1  serial line, registered

Behaviour:
- Reset (async) forces: state IDLE, tx_o=1 (line idle high), tx_ready_o=1, tx_busy_o=0, tx_done_o=0, and clears all counters and the shift register.
- States: IDLE, START, DATA, PARITY, STOP (BREAK only with the optional feature).
- Handshake: a word is accepted on the rising edge where tx_valid_i && tx_ready_o. tx_ready_o = (state==IDLE). On acceptance, data, cfg_bits_i, cfg_parity_i and cfg_stop_i are latched. Config changes mid-frame have no effect.
- Latency: tx_o falls to 0 in the cycle immediately after the accepting edge.
- START: tx_o=0 for OVERSAMPLE baud ticks, then go to DATA.
- DATA: tx_o = shift_reg[0]. After OVERSAMPLE ticks, shift right. After N bits (N from latched cfg_bits), go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: tx_o = XOR of the N sent data bits for even parity, or its inverse for odd parity. Lasts OVERSAMPLE ticks, then go to STOP.
- STOP: tx_o=1 for OVERSAMPLE, 3*OVERSAMPLE/2, or 2*OVERSAMPLE ticks, per the latched stop setting.
  - In the cycle of the final stop tick: tx_done_o=1 and the next state is IDLE.
- Tick counter:
  - width clog2(2*OVERSAMPLE), clears on every state change.
  - advances only while baud_i=1.
  - baud_i is ignored in IDLE.
- Back-to-back: if tx_valid_i is held high, the next word is accepted on the first cycle in IDLE. There is no extra idle-high time beyond the stop bits.
- tx_busy_o = !IDLE. tx_done_o is never asserted outside the STOP→IDLE transition.
- Data bits above N are ignored for both transmission and parity.
- Reset mid-frame: the line goes high immediately, no tx_done_o pulse is generated, and the partial word is discarded.

Optional Feature:
- Macro UART_TX_BREAK_EN.
- When defined:
  - Adds input break_i (1 bit).
  - In IDLE, break_i=1 has priority over tx_valid_i and enters BREAK. tx_o=0 and tx_ready_o=0 while break_i stays high.
  - When break_i falls, go to STOP for the stop duration latched at break entry (cfg_stop_i sampled when BREAK is entered), then return to IDLE with no tx_done_o pulse.
  - break_i asserted mid-frame is ignored until IDLE.
- When undefined: the break_i port and the BREAK state are absent, and behaviour is exactly as above.

Decomposition:
- Shared package uart_pkg contains:
  - state enum
  - cfg encodings: parity (PAR_NONE/EVEN/ODD), stop (STOP_1/STOP_1P5/STOP_2), bits (BITS_5..BITS_8)
  - function for stop-tick count
  - function for masked parity of a word given N
- No sub-module is needed. The baud generator stays external and shared with the receiver.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 → tx_o = 0,1,0,1,0,0,1,0,1 then stop 1. Each bit lasts 16 ticks. Exactly one tx_done_o pulse; ready is low for 160 ticks.
- 7E2, send 0xC1 → data 1000001 LSB-first, parity 0 (two ones), stop high for 32 ticks. Bit 7 is ignored.
- 5O1.5, send 0xFF → five 1 data bits, parity 0 (odd count already), stop lasts 24 ticks. tx_done_o is asserted on tick 24.
- Back-to-back: tx_valid_i held high with 0x55 then 0x0F, 8N1 → the second start bit begins on the cycle after the first frame's IDLE acceptance. There is no idle gap, and two tx_done_o pulses occur.
- Reset asserted during DATA bit 3 → tx_o=1 and tx_ready_o=1 immediately, no tx_done_o. A subsequent 0x3C is transmitted cleanly.
- (UART_TX_BREAK_EN) break_i high for 40 ticks in IDLE while tx_valid_i=1 → tx_o=0 for 40 ticks, then stop period. The pending word is accepted only after returning to IDLE.
